// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART byte transmitter among NUM_CH requesters.
// Each grant is sent as a frame: header, payload bytes MSB first, optional XOR checksum.
module uart_tx_scheduler #(
    parameter int         NUM_CH     = 4,
    parameter int         DATA_WIDTH = 16,
    parameter logic [7:0] HDR_BASE   = 8'hA0,
    parameter bit         CHKSUM_EN  = 1'b1
) (
    input  logic                         Clk,
    input  logic                         Rst_n,
    input  logic [NUM_CH-1:0]            req,
    input  logic [NUM_CH*DATA_WIDTH-1:0] req_data,
    output logic [NUM_CH-1:0]            ack,
    output logic [7:0]                   byte_data,
    output logic                         byte_send_en,
    input  logic                         byte_tx_done,
    output logic                         busy,
    output logic [2:0]                   grant_id,
    output logic                         frame_done
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int FL = 1 + NB + (CHKSUM_EN ? 1 : 0);
    localparam int BW = FL * 8;
    localparam int CW = $clog2(FL + 1);

    typedef enum logic [2:0] {IDLE, ARB, LOAD, WAIT, DONE} state_t;
    state_t state, state_nxt;

    logic [NUM_CH-1:0][DATA_WIDTH-1:0] ch_data;
    logic [2:0]            rr_ptr, winner;
    logic                  found;
    int                    best_d, d;
    logic [DATA_WIDTH-1:0] win_data;
    logic [7:0]            win_chk;
    logic [BW-1:0]         frame_buf, frame_nxt;
    logic [CW-1:0]         cnt;
    logic                  last_byte;
    logic [NUM_CH-1:0]     ack_nxt;
    logic                  send_nxt, done_nxt;

    assign ch_data   = req_data;
    assign last_byte = (cnt == CW'(FL - 1));

    // Winner is the requester at the smallest distance after rr_ptr, wrapping.
    always_comb begin
        best_d   = NUM_CH;
        d        = 0;
        winner   = '0;
        win_data = '0;
        win_chk  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            d = (i + NUM_CH - int'(rr_ptr) - 1) % NUM_CH;
            if (req[i] && d < best_d) begin
                best_d = d;
                winner = 3'(i);
            end
        end
        found = (best_d < NUM_CH);
        for (int i = 0; i < NUM_CH; i++)
            if (winner == 3'(i)) win_data = ch_data[i];
        for (int b = 0; b < NB; b++)
            win_chk = win_chk ^ win_data[b*8 +: 8];
        frame_nxt = '0;
        frame_nxt[BW-1 -: 8] = HDR_BASE | {5'b0, winner};
        frame_nxt[BW-9 -: DATA_WIDTH] = win_data;
        if (CHKSUM_EN) frame_nxt[7:0] = win_chk;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (|req) state_nxt = ARB;
            ARB:  state_nxt = found ? LOAD : IDLE;
            LOAD: state_nxt = WAIT;
            WAIT: if (byte_tx_done) state_nxt = last_byte ? DONE : LOAD;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ack_nxt  = '0;
        send_nxt = 1'b0;
        done_nxt = 1'b0;
        case (state)
            ARB:  if (found) ack_nxt = {{(NUM_CH-1){1'b0}}, 1'b1} << winner;
            LOAD: send_nxt = 1'b1;
            DONE: done_nxt = 1'b1;
            default: ;
        endcase
    end

    // Frame buffer shifts left one byte per completed byte; the top byte is always next.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ack          <= '0;
            byte_data    <= '0;
            byte_send_en <= 1'b0;
            busy         <= 1'b0;
            grant_id     <= '0;
            frame_done   <= 1'b0;
            rr_ptr       <= 3'(NUM_CH - 1);
            cnt          <= '0;
            frame_buf    <= '0;
        end else begin
            ack          <= ack_nxt;
            byte_send_en <= send_nxt;
            frame_done   <= done_nxt;
            case (state)
                ARB: if (found) begin
                    grant_id  <= winner;
                    busy      <= 1'b1;
                    frame_buf <= frame_nxt;
                    cnt       <= '0;
                end
                LOAD: byte_data <= frame_buf[BW-1 -: 8];
                WAIT: if (byte_tx_done) begin
                    cnt       <= cnt + CW'(1);
                    frame_buf <= frame_buf << 8;
                end
                DONE: begin
                    rr_ptr <= grant_id;
                    busy   <= 1'b0;
                    cnt    <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed and random frames against a round-robin/frame model.
module tb_uart_tx_scheduler;
    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [3:0]  req = '0, req0 = '0;
    logic [63:0] req_data = '0;
    logic        tx_pulse = 1'b0, tx_pulse0 = 1'b0, tx_man = 1'b0;
    bit          tx_auto = 1'b1;
    logic        byte_tx_done, byte_tx_done0;

    logic [3:0] ack, ack0;
    logic [7:0] byte_data, byte_data0;
    logic       byte_send_en, byte_send_en0, busy, busy0, frame_done, frame_done0;
    logic [2:0] grant_id, grant_id0;

    always #5 Clk = ~Clk;
    assign byte_tx_done  = tx_pulse | tx_man;
    assign byte_tx_done0 = tx_pulse0;

    uart_tx_scheduler #(.NUM_CH(4), .DATA_WIDTH(16), .HDR_BASE(8'hA0), .CHKSUM_EN(1'b1)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .req(req), .req_data(req_data), .ack(ack),
        .byte_data(byte_data), .byte_send_en(byte_send_en), .byte_tx_done(byte_tx_done),
        .busy(busy), .grant_id(grant_id), .frame_done(frame_done));

    uart_tx_scheduler #(.NUM_CH(4), .DATA_WIDTH(16), .HDR_BASE(8'hA0), .CHKSUM_EN(1'b0)) dut0 (
        .Clk(Clk), .Rst_n(Rst_n), .req(req0), .req_data(req_data), .ack(ack0),
        .byte_data(byte_data0), .byte_send_en(byte_send_en0), .byte_tx_done(byte_tx_done0),
        .busy(busy0), .grant_id(grant_id0), .frame_done(frame_done0));

    logic [7:0]  q1[$], q0[$];
    logic [15:0] chd[4];
    int n_ack = 0, n_fd = 0, n_multi = 0, n_both = 0, n_tx0 = 0;
    int n_chk = 0, n_err = 0;
    int rr = 3;
    int cd = 0, cd0 = 0;

    // Byte transmitter models: finish each byte 1..4 cycles after its start pulse.
    always @(negedge Clk) begin
        tx_pulse = 1'b0;
        if (!Rst_n) cd = 0;
        else begin
            if (cd > 0) begin cd--; if (cd == 0) tx_pulse = 1'b1; end
            if (byte_send_en && tx_auto) cd = $urandom_range(4, 1);
        end
    end
    always @(negedge Clk) begin
        tx_pulse0 = 1'b0;
        if (!Rst_n) cd0 = 0;
        else begin
            if (cd0 > 0) begin cd0--; if (cd0 == 0) begin tx_pulse0 = 1'b1; n_tx0++; end end
            if (byte_send_en0) cd0 = $urandom_range(4, 1);
        end
    end

    always @(negedge Clk) begin
        if (byte_send_en)  q1.push_back(byte_data);
        if (byte_send_en0) q0.push_back(byte_data0);
        if (ack != 0) n_ack++;
        if ($countones(ack) > 1) n_multi++;
        if (ack != 0 && frame_done) n_both++;
        if (frame_done) n_fd++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_next(input int p, input logic [3:0] m);
        for (int off = 1; off <= 4; off++)
            if (m[(p + off) % 4]) return (p + off) % 4;
        return -1;
    endfunction

    function automatic logic [31:0] exp_frame(input int c, input logic [15:0] dat);
        logic [7:0] h;
        h = 8'hA0 | 8'(c);
        return {h, dat, dat[15:8] ^ dat[7:0]};
    endfunction

    task automatic apply_data();
        for (int c = 0; c < 4; c++) req_data[c*16 +: 16] = chd[c];
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge Clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"}, ack, 0);           check({tag, "_byte_data"}, byte_data, 0);
        check({tag, "_send_en"}, byte_send_en, 0); check({tag, "_busy"}, busy, 0);
        check({tag, "_grant_id"}, grant_id, 0); check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_busy0"}, busy0, 0);       check({tag, "_ack0"}, ack0, 0);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst_n = 1'b0; req = '0; req0 = '0;
        #1 check_reset_outputs("reset");
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1; rr = 3;
        q1.delete(); q0.delete();
    endtask

    task automatic wait_ack(output int idx, output int lat);
        idx = -1; lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            lat = i + 1;
            if (ack != 0) begin
                for (int k = 0; k < 4; k++) if (ack[k]) idx = k;
                break;
            end
        end
        check("ack_seen", 64'(idx >= 0), 1);
    endtask

    task automatic wait_fd(input bit which);
        bit ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge Clk);
            if (which ? frame_done0 : frame_done) begin ok = 1'b1; break; end
        end
        check("frame_done_seen", 64'(ok), 1);
    endtask

    task automatic check_frame(input int w, input logic [31:0] e);
        check($sformatf("frame_len_ch%0d", w), q1.size(), 4);
        for (int k = 0; k < 4 && k < q1.size(); k++)
            check($sformatf("byte%0d_ch%0d", k, w), q1[k], e[31-8*k -: 8]);
    endtask

    // Serve frames for the requesting set; requesters drop req on ack unless hold is set.
    task automatic serve(input logic [3:0] mask, input bit hold, input int nfr, input bit chk_lat);
        logic [3:0] pend;
        int w, idx, lat;
        logic [31:0] e;
        pend = mask; q1.delete(); apply_data(); req = mask;
        for (int f = 0; f < nfr && pend != 0; f++) begin
            w = rr_next(rr, pend);
            e = exp_frame(w, chd[w]);
            wait_ack(idx, lat);
            check("grant_ch", idx, w);
            check("grant_id", grant_id, w);
            check("busy_at_ack", busy, 1);
            if (chk_lat) begin
                check("ack_latency", lat, 2);
                @(negedge Clk);
                check("first_send_en", byte_send_en, 1);
                check("hdr_byte", byte_data, e[31:24]);
            end
            if (idx >= 0) begin
                if (!hold) begin req[idx] = 1'b0; pend[idx] = 1'b0; end
                chd[idx] = 16'($urandom);
                apply_data();
            end else pend = '0;
            wait_fd(1'b0);
            check_frame(w, e);
            check("busy_at_done", busy, 0);
            rr = w;
            q1.delete();
        end
        req = '0;
    endtask

    initial begin
        int a, f, idx, lat, ns;
        logic [31:0] e;
        for (int c = 0; c < 4; c++) chd[c] = 16'($urandom);
        do_reset();

        // ch2 alone with a known payload
        chd[2] = 16'h1234;
        settle(1); a = n_ack; f = n_fd;
        serve(4'b0100, 1'b0, 1, 1'b1);
        settle(3);
        check("t1_one_ack", n_ack - a, 1);
        check("t1_one_frame_done", n_fd - f, 1);

        // all four after reset
        do_reset();
        serve(4'b1111, 1'b0, 4, 1'b0);

        // ch1 and ch3 held high: alternate
        serve(4'b1010, 1'b1, 4, 1'b0);
        settle(5);
        check("t3_idle_after_hold", busy, 0);

        // no-checksum variant
        chd[0] = 16'hBEEF; apply_data();
        @(negedge Clk); q0.delete(); n_tx0 = 0; req0 = 4'b0001;
        idx = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (ack0 != 0) begin idx = (ack0 == 4'b0001) ? 0 : 9; break; end
        end
        check("t4_ack0_ch0", idx, 0);
        check("t4_grant_id0", grant_id0, 0);
        req0 = '0;
        wait_fd(1'b1);
        settle(1);
        check("t4_len", q0.size(), 3);
        if (q0.size() == 3) begin
            check("t4_b0", q0[0], 8'hA0); check("t4_b1", q0[1], 8'hBE); check("t4_b2", q0[2], 8'hEF);
        end
        check("t4_tx_done_count", n_tx0, 3);

        // reset in WAIT of byte 2
        @(negedge Clk);
        q1.delete(); chd[2] = 16'($urandom); apply_data(); req = 4'b0100; ns = 0;
        for (int i = 0; i < 200 && ns < 2; i++) begin
            @(negedge Clk);
            if (ack != 0) req = '0;
            if (byte_send_en) ns++;
        end
        check("t5_reached_byte2", ns, 2);
        f = n_fd;
        #1 Rst_n = 1'b0; req = '0;
        #1 check_reset_outputs("t5_async");
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1; rr = 3;
        settle(20);
        check("t5_no_frame_done", n_fd - f, 0);
        serve(4'b1010, 1'b0, 2, 1'b0);

        // spurious done in IDLE and a req pulse dropped before ARB
        settle(2); a = n_ack; f = n_fd;
        @(negedge Clk) tx_man = 1'b1;
        @(negedge Clk) tx_man = 1'b0; req = 4'b0010;
        @(negedge Clk) req = '0;
        settle(10);
        check("t6_no_ack", n_ack - a, 0);
        check("t6_not_busy", busy, 0);
        check("t6_no_bytes", q1.size(), 0);
        check("t6_no_frame_done", n_fd - f, 0);

        // spurious done in LOAD
        tx_auto = 1'b0; chd[0] = 16'($urandom); apply_data(); q1.delete();
        e = exp_frame(rr_next(rr, 4'b0001), chd[0]);
        @(negedge Clk) req = 4'b0001;
        wait_ack(idx, lat);
        check("t6_grant", idx, rr_next(rr, 4'b0001));
        tx_man = 1'b1; req = '0;
        @(negedge Clk) tx_man = 1'b0;
        check("t6_send_after_load", byte_send_en, 1);
        settle(8);
        check("t6_load_done_ignored", q1.size(), 1);
        check("t6_busy_waiting", busy, 1);
        tx_auto = 1'b1;
        @(negedge Clk) tx_man = 1'b1;
        @(negedge Clk) tx_man = 1'b0;
        wait_fd(1'b0);
        check_frame(0, e);
        rr = 0; q1.delete();

        // random request sets
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 4; c++) chd[c] = 16'($urandom);
            settle(1);
            serve(4'($urandom_range(15, 1)), 1'b0, 4, 1'b0);
        end

        settle(5);
        check("ack_onehot", n_multi, 0);
        check("ack_frame_done_disjoint", n_both, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
